// File: rtl/round_controller.sv
// ---------------------------------------------------------------------------
// round_controller
//
// Sequences a DiveKick match: intro hold, fight, post-hit freeze, round
// restart and match over. It keeps the round scores and drives Freeze and
// Restart to the player and frame logic. All round timing is counted in
// frames, which are rising edges of frame_clk, rather than in Clk cycles.
//
// Ports
//   Clk           in   50 MHz system clock
//   Reset         in   synchronous, active-low reset
//   frame_clk     in   ~60 Hz frame strobe (asynchronous level)
//   p1_hit        in   player 1 kick connects this cycle (level)
//   p2_hit        in   player 2 kick connects this cycle (level)
//   start         in   new-match request button (asynchronous level)
//   Freeze        out  1 = players/physics held
//   Restart       out  one-Clk pulse: reload player positions/states
//   p1_score      out  rounds won by player 1
//   p2_score      out  rounds won by player 2
//   round_result  out  last round: 00 none, 01 P1, 10 P2, 11 draw
//   match_winner  out  00 none, 01 P1, 10 P2
//   round_state   out  INTRO=0 FIGHT=1 HIT_FREEZE=2 RESTART=3 MATCH_OVER=4
// ---------------------------------------------------------------------------
module round_controller #(
  parameter int WIN_ROUNDS    = 3,
  parameter int INTRO_FRAMES  = 60,
  parameter int FREEZE_FRAMES = 90,
  parameter int ROUND_FRAMES  = 1800
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_clk,
  input  logic       p1_hit,
  input  logic       p2_hit,
  input  logic       start,
  output logic       Freeze,
  output logic       Restart,
  output logic [2:0] p1_score,
  output logic [2:0] p2_score,
  output logic [1:0] round_result,
  output logic [1:0] match_winner,
  output logic [2:0] round_state
);

  typedef enum logic [2:0] {
    INTRO      = 3'd0,
    FIGHT      = 3'd1,
    HIT_FREEZE = 3'd2,
    RESTART    = 3'd3,
    MATCH_OVER = 3'd4
  } state_t;

  localparam int CW = 16;

  // Counter values at which the Nth frame tick lands (the counter holds the
  // number of ticks already seen in the current state).
  localparam logic [CW-1:0] INTRO_LAST  = CW'(INTRO_FRAMES - 1);
  localparam logic [CW-1:0] FREEZE_LAST = CW'(FREEZE_FRAMES - 1);
  localparam logic [CW-1:0] ROUND_LAST  = CW'((ROUND_FRAMES == 0) ? 0 : ROUND_FRAMES - 1);
  localparam bit            TIMEOUT_EN  = (ROUND_FRAMES != 0);
  localparam logic [2:0]    WIN         = 3'(WIN_ROUNDS);

  state_t        state;
  logic [CW-1:0] frame_cnt;

  // Bits [1:0] form the 2-FF synchronizer; bit 2 is the previous synchronized
  // value used for rising-edge detection.
  logic [2:0] frame_sync;
  logic [2:0] start_sync;
  logic       frame_tick;
  logic       start_tick;

  assign frame_tick  = frame_sync[1] & ~frame_sync[2];
  assign start_tick  = start_sync[1] & ~start_sync[2];
  assign round_state = state;

  // Every state transition clears frame_cnt so each state counts its own
  // frames from zero. A hit in FIGHT is checked before the timeout so that a
  // hit landing on the timeout tick is scored as a hit.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state        <= INTRO;
      frame_cnt    <= '0;
      frame_sync   <= '0;
      start_sync   <= '0;
      Freeze       <= 1'b1;
      Restart      <= 1'b0;
      p1_score     <= '0;
      p2_score     <= '0;
      round_result <= 2'b00;
      match_winner <= 2'b00;
    end else begin
      frame_sync <= {frame_sync[1:0], frame_clk};
      start_sync <= {start_sync[1:0], start};
      Restart    <= 1'b0;
      if (frame_tick) begin
        frame_cnt <= frame_cnt + CW'(1);
      end

      case (state)
        INTRO: begin
          if (frame_tick && frame_cnt == INTRO_LAST) begin
            state     <= FIGHT;
            Freeze    <= 1'b0;
            frame_cnt <= '0;
          end
        end

        FIGHT: begin
          if (p1_hit || p2_hit) begin
            state     <= HIT_FREEZE;
            Freeze    <= 1'b1;
            frame_cnt <= '0;
            if (p1_hit && p2_hit) begin
              round_result <= 2'b11;
            end else if (p1_hit) begin
              round_result <= 2'b01;
              if (p1_score < WIN) begin
                p1_score <= p1_score + 3'd1;
              end
            end else begin
              round_result <= 2'b10;
              if (p2_score < WIN) begin
                p2_score <= p2_score + 3'd1;
              end
            end
          end else if (TIMEOUT_EN && frame_tick && frame_cnt == ROUND_LAST) begin
            state        <= HIT_FREEZE;
            Freeze       <= 1'b1;
            frame_cnt    <= '0;
            round_result <= 2'b11;
          end
        end

        HIT_FREEZE: begin
          if (frame_tick && frame_cnt == FREEZE_LAST) begin
            frame_cnt <= '0;
            if (p1_score == WIN) begin
              state        <= MATCH_OVER;
              match_winner <= 2'b01;
            end else if (p2_score == WIN) begin
              state        <= MATCH_OVER;
              match_winner <= 2'b10;
            end else begin
              state        <= RESTART;
              Restart      <= 1'b1;
              round_result <= 2'b00;
            end
          end
        end

        RESTART: begin
          state     <= INTRO;
          Freeze    <= 1'b1;
          frame_cnt <= '0;
        end

        MATCH_OVER: begin
          if (start_tick) begin
            state        <= RESTART;
            Restart      <= 1'b1;
            frame_cnt    <= '0;
            p1_score     <= '0;
            p2_score     <= '0;
            match_winner <= 2'b00;
            round_result <= 2'b00;
          end
        end

        default: begin
          state     <= INTRO;
          Freeze    <= 1'b1;
          frame_cnt <= '0;
        end
      endcase
    end
  end

endmodule
